jtag_cmd_sysclk_bridge: RTL and testbench

- System-clock half of a multi-channel JTAG debug bridge.
- Receives Update-IR / Update-DR toggle events and a quasi-static shift-register snapshot from the TCK domain, synchronises them, and decodes the latched IR into one of NUM_CH channels.
- Dispatches a valid/ready command to the selected channel and captures that channel's response into a register the TCK side shifts out.
- Generalises the fixed 2-bit-IR, 38-bit, action/no-action decoding of the existing Nios II debug path to N channels with handshaking and error reporting.

---
 rtl/jtag_cmd_sysclk_bridge_pkg.sv | 20 ++
 rtl/jtag_cmd_sysclk_bridge_if.sv | 35 +++
 rtl/jtag_cmd_sysclk_bridge_toggle_sync.sv | 28 ++
 rtl/jtag_cmd_sysclk_bridge.sv | 146 ++++++++++++++
 tb/tb_jtag_cmd_sysclk_bridge.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_cmd_sysclk_bridge_pkg.sv
// Shared definitions for the system-clock half of the JTAG command bridge.
// Contents: FSM state encoding, err_flags bit indices, IR width helper.
package jtag_cmd_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  localparam int ERR_OVERRUN = 0;
  localparam int ERR_BADCH   = 1;
  localparam int ERR_TIMEOUT = 2;

  // IR width is max(1, clog2(num_ch)) so a single channel still has a 1-bit IR.
  function automatic int ir_width(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/jtag_cmd_sysclk_bridge_if.sv
// Bus bundle between the TCK-side snapshot, the command channels and the
// system-clock bridge.
//   slave  : bridge view (TCK snapshot and channel responses in, commands out)
//   master : driver view (opposite directions)
interface jtag_cmd_sysclk_bridge_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int IR_W   = jtag_cmd_bridge_pkg::ir_width(NUM_CH)
);
  logic                     udr_toggle;
  logic                     uir_toggle;
  logic [IR_W-1:0]          ir_in;
  logic [DATA_W:0]          sr_in;
  logic [NUM_CH-1:0]        cmd_valid;
  logic [DATA_W-1:0]        cmd_data;
  logic [NUM_CH-1:0]        cmd_ready;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [NUM_CH*DATA_W-1:0] rsp_data;
  logic [NUM_CH-1:0]        noact_pulse;
  logic [DATA_W-1:0]        capture_data;
  logic                     capture_toggle;
  logic                     busy;
  logic [2:0]               err_flags;
  logic                     err_clear;

  modport slave (
    input  udr_toggle, uir_toggle, ir_in, sr_in, cmd_ready, rsp_valid, rsp_data, err_clear,
    output cmd_valid, cmd_data, noact_pulse, capture_data, capture_toggle, busy, err_flags
  );

  modport master (
    output udr_toggle, uir_toggle, ir_in, sr_in, cmd_ready, rsp_valid, rsp_data, err_clear,
    input  cmd_valid, cmd_data, noact_pulse, capture_data, capture_toggle, busy, err_flags
  );
endinterface

// File: rtl/jtag_cmd_sysclk_bridge_toggle_sync.sv
// Toggle synchroniser: SYNC_STAGES-deep flop chain followed by an edge
// detector that turns each toggle flip into a one-cycle pulse.
//   clk, reset : system clock, async active-high reset
//   toggle_i   : asynchronous toggle from the TCK domain
//   evt_o      : one-cycle pulse per toggle flip
module jtag_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic toggle_i,
  output logic evt_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt_o = sync_q[SYNC_STAGES-1] ^ prev_q;
endmodule

// File: rtl/jtag_cmd_sysclk_bridge.sv
// System-clock half of a multi-channel JTAG debug bridge. Synchronises the
// Update-IR / Update-DR toggles, decodes the latched IR into a channel,
// dispatches a valid/ready command and captures the channel's response for
// the TCK side to shift out.
//   clk, reset : system clock, async active-high reset
//   bus        : jtag_cmd_sysclk_bridge_if.slave (TCK snapshot, channel
//                command/response, capture, busy, sticky err_flags)
// Optional: define JTAG_CMD_BRIDGE_TIMEOUT_EN to add a transaction watchdog
// that aborts after TIMEOUT_CYCLES with an all-ones capture and err_flags[2].
//
// state    | meaning
// IDLE     | waiting for Update-DR
// DISPATCH | cmd_valid asserted to ch_q, waiting for cmd_ready
// WAIT_RSP | waiting for rsp_valid from ch_q
module jtag_cmd_sysclk_bridge
  import jtag_cmd_bridge_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IR_W           = ir_width(NUM_CH)
) (
  input logic                    clk,
  input logic                    reset,
  jtag_cmd_sysclk_bridge_if.slave bus
);
  logic              udr_evt, uir_evt;
  state_t            state_q;
  logic [IR_W-1:0]   ir_q, ch_q;
  logic [NUM_CH-1:0] cmd_valid_q, noact_q, ch_oh;
  logic [DATA_W-1:0] cmd_data_q, capture_data_q, rsp_sel;
  logic              capture_toggle_q;
  logic [2:0]        err_q;
  logic              ir_bad, ready_hit, rsp_hit;

  jtag_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk(clk), .reset(reset), .toggle_i(bus.udr_toggle), .evt_o(udr_evt)
  );
  jtag_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk(clk), .reset(reset), .toggle_i(bus.uir_toggle), .evt_o(uir_evt)
  );

  // IR may be wider than needed to select NUM_CH channels; codes past the
  // last channel are reported instead of being decoded.
  assign ir_bad    = int'(ir_q) >= NUM_CH;
  assign ch_oh     = NUM_CH'(1) << ch_q;
  assign ready_hit = |(bus.cmd_ready & ch_oh);
  assign rsp_hit   = |(bus.rsp_valid & ch_oh);

  always_comb begin
    rsp_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == IR_W'(c)) rsp_sel = bus.rsp_data[c*DATA_W +: DATA_W];
    end
  end

`ifdef JTAG_CMD_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, ERR_TIMEOUT};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      ir_q             <= '0;
      ch_q             <= '0;
      cmd_valid_q      <= '0;
      cmd_data_q       <= '0;
      noact_q          <= '0;
      capture_data_q   <= '0;
      capture_toggle_q <= 1'b0;
      err_q            <= '0;
`ifdef JTAG_CMD_BRIDGE_TIMEOUT_EN
      tmo_q            <= '0;
`endif
    end else begin
      noact_q <= '0;
      // ir_q updates alongside any same-edge decode, which still sees the old value.
      if (uir_evt) ir_q <= bus.ir_in;
      // Individual error sets below are later assignments, so a set wins over clear.
      if (bus.err_clear) err_q <= '0;

      case (state_q)
        IDLE: begin
          if (udr_evt) begin
            if (ir_bad) begin
              err_q[ERR_BADCH] <= 1'b1;
            end else if (!bus.sr_in[DATA_W]) begin
              noact_q <= NUM_CH'(1) << ir_q;
            end else begin
              ch_q        <= ir_q;
              cmd_data_q  <= bus.sr_in[DATA_W-1:0];
              cmd_valid_q <= NUM_CH'(1) << ir_q;
              state_q     <= DISPATCH;
`ifdef JTAG_CMD_BRIDGE_TIMEOUT_EN
              tmo_q       <= '0;
`endif
            end
          end
        end
        DISPATCH: begin
          if (ready_hit) begin
            cmd_valid_q <= '0;
            state_q     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_hit) begin
            capture_data_q   <= rsp_sel;
            capture_toggle_q <= ~capture_toggle_q;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (udr_evt && state_q != IDLE) err_q[ERR_OVERRUN] <= 1'b1;

`ifdef JTAG_CMD_BRIDGE_TIMEOUT_EN
      if (state_q != IDLE) begin
        if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          capture_data_q     <= '1;
          capture_toggle_q   <= ~capture_toggle_q;
          err_q[ERR_TIMEOUT] <= 1'b1;
          cmd_valid_q        <= '0;
          state_q            <= IDLE;
        end else begin
          tmo_q <= tmo_q + TMO_W'(1);
        end
      end
`endif
    end
  end

  assign bus.cmd_valid      = cmd_valid_q;
  assign bus.cmd_data       = cmd_data_q;
  assign bus.noact_pulse    = noact_q;
  assign bus.capture_data   = capture_data_q;
  assign bus.capture_toggle = capture_toggle_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.err_flags      = err_q;
endmodule

// File: tb/tb_jtag_cmd_sysclk_bridge.sv
module tb_jtag_cmd_sysclk_bridge;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int IR_W   = 3;
  localparam int SYNC   = 2;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] sb_q[$];
  logic exp_tog = 1'b0;

  jtag_cmd_sysclk_bridge_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IR_W(IR_W)) bus ();

  jtag_cmd_sysclk_bridge #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SYNC_STAGES(SYNC),
    .TIMEOUT_CYCLES(TMO), .IR_W(IR_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IR_W-1:0] ir;
    logic            act;
    logic [31:0]     payload;
    int              dly;
    logic [31:0]     rsp;
    logic [3:0]      exp_cv;
    logic [3:0]      exp_noact;
    logic [2:0]      exp_err;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ir(input logic [IR_W-1:0] ir);
    bus.ir_in = ir;
    bus.uir_toggle = ~bus.uir_toggle;
    repeat (4) tick();
  endtask

  // Flip udr, then return just after the edge where the command should appear.
  task automatic fire_udr(input logic act, input logic [31:0] payload);
    bus.sr_in = {act, payload};
    bus.udr_toggle = ~bus.udr_toggle;
    tick();
    tick();
    check("cmd_valid_early", bus.cmd_valid, 64'd0);
    tick();
  endtask

  task automatic finish_cmd(input int ch, input int dly, input logic [31:0] rsp);
    logic [31:0] exp;
    bus.cmd_ready = ~(4'b0001 << ch);
    for (int i = 0; i < dly; i++) begin
      tick();
      check("cmd_hold", bus.cmd_valid, 64'd1 << ch);
    end
    bus.cmd_ready = 4'b0001 << ch;
    tick();
    bus.cmd_ready = '0;
    check("cmd_valid_drop", bus.cmd_valid, 64'd0);
    check("busy_wait_rsp", bus.busy, 64'd1);
    for (int c = 0; c < NUM_CH; c++) bus.rsp_data[c*DATA_W +: DATA_W] = (c == ch) ? rsp : ~rsp;
    bus.rsp_valid = 4'b0001 << ch;
    tick();
    bus.rsp_valid = '0;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got capture 0x%0h with no expected entry", bus.capture_data);
    end else begin
      exp = sb_q.pop_front();
      exp_tog = ~exp_tog;
      check("capture_data", bus.capture_data, exp);
      check("capture_toggle", bus.capture_toggle, exp_tog);
      check("busy_done", bus.busy, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.udr_toggle = 1'b0;
    bus.uir_toggle = 1'b0;
    bus.ir_in      = '0;
    bus.sr_in      = '0;
    bus.cmd_ready  = '0;
    bus.rsp_valid  = '0;
    bus.rsp_data   = '0;
    bus.err_clear  = 1'b0;

    vecs[0] = '{3'd2, 1'b1, 32'hDEADBEEF, 2, 32'h12345678, 4'b0100, 4'b0000, 3'b000};
    vecs[1] = '{3'd1, 1'b0, 32'h00000000, 0, 32'h00000000, 4'b0000, 4'b0010, 3'b000};
    vecs[2] = '{3'd5, 1'b1, 32'hA5A5A5A5, 0, 32'h00000000, 4'b0000, 4'b0000, 3'b010};
    vecs[3] = '{3'd0, 1'b1, 32'h00000001, 0, 32'hCAFEF00D, 4'b0001, 4'b0000, 3'b000};
    vecs[4] = '{3'd3, 1'b1, 32'hFFFF0000, 1, 32'h0BADF00D, 4'b1000, 4'b0000, 3'b000};
    vecs[5] = '{3'd7, 1'b0, 32'h00000000, 0, 32'h00000000, 4'b0000, 4'b0000, 3'b010};

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_valid", bus.cmd_valid, 64'd0);
    check("rst_busy", bus.busy, 64'd0);
    check("rst_err", bus.err_flags, 64'd0);
    check("rst_capture", bus.capture_data, 64'd0);
    check("rst_cap_toggle", bus.capture_toggle, 64'd0);
    check("rst_noact", bus.noact_pulse, 64'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      set_ir(vecs[i].ir);
      if (vecs[i].exp_cv != 0) sb_q.push_back(vecs[i].rsp);
      fire_udr(vecs[i].act, vecs[i].payload);
      check($sformatf("v%0d_cmd_valid", i), bus.cmd_valid, vecs[i].exp_cv);
      check($sformatf("v%0d_noact", i), bus.noact_pulse, vecs[i].exp_noact);
      check($sformatf("v%0d_err", i), bus.err_flags, vecs[i].exp_err);
      if (vecs[i].exp_cv != 0) begin
        check($sformatf("v%0d_cmd_data", i), bus.cmd_data, vecs[i].payload);
        check($sformatf("v%0d_busy", i), bus.busy, 64'd1);
        finish_cmd(int'(vecs[i].ir), vecs[i].dly, vecs[i].rsp);
      end else begin
        check($sformatf("v%0d_busy_idle", i), bus.busy, 64'd0);
        tick();
        check($sformatf("v%0d_noact_gone", i), bus.noact_pulse, 64'd0);
        check($sformatf("v%0d_cmd_valid_idle", i), bus.cmd_valid, 64'd0);
        if (vecs[i].exp_err != 0) begin
          bus.err_clear = 1'b1;
          tick();
          bus.err_clear = 1'b0;
          check($sformatf("v%0d_err_cleared", i), bus.err_flags, 64'd0);
        end
      end
    end

    // Overrun plus mid-transaction IR change on channel 1.
    set_ir(3'd1);
    sb_q.push_back(32'h55667788);
    fire_udr(1'b1, 32'h11112222);
    check("ov_cmd_valid", bus.cmd_valid, 64'b0010);
    bus.cmd_ready = 4'b0010;
    tick();
    bus.cmd_ready = '0;
    bus.ir_in = 3'd0;
    bus.uir_toggle = ~bus.uir_toggle;
    bus.sr_in = {1'b1, 32'h33334444};
    bus.udr_toggle = ~bus.udr_toggle;
    repeat (4) tick();
    check("ov_err", bus.err_flags, 64'b001);
    check("ov_busy", bus.busy, 64'd1);
    check("ov_cmd_valid_low", bus.cmd_valid, 64'd0);
    bus.rsp_data = {4{32'h99999999}};
    bus.rsp_valid = 4'b0001;
    tick();
    bus.rsp_valid = '0;
    check("ov_wrong_ch_toggle", bus.capture_toggle, exp_tog);
    check("ov_wrong_ch_busy", bus.busy, 64'd1);
    finish_cmd(1, 0, 32'h55667788);

    // Simultaneous Update-IR/Update-DR: decode uses old ir_q (0).
    sb_q.push_back(32'hA0A0B0B0);
    bus.ir_in = 3'd6;
    bus.uir_toggle = ~bus.uir_toggle;
    fire_udr(1'b1, 32'h0F0F0F0F);
    check("same_cycle_cmd_valid", bus.cmd_valid, 64'b0001);
    check("same_cycle_cmd_data", bus.cmd_data, 64'h0F0F0F0F);
    finish_cmd(0, 1, 32'hA0A0B0B0);

    // err_clear colliding with a new bad-channel error (ir_q is now 6).
    check("pre_collide_err", bus.err_flags, 64'b001);
    bus.sr_in = {1'b1, 32'h00000001};
    bus.udr_toggle = ~bus.udr_toggle;
    tick();
    tick();
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    check("collide_err", bus.err_flags, 64'b010);
    check("collide_busy", bus.busy, 64'd0);
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    check("collide_cleared", bus.err_flags, 64'd0);

    // Asynchronous reset while in DISPATCH.
    set_ir(3'd3);
    fire_udr(1'b1, 32'hFEEDFACE);
    check("rst_mid_cmd_valid", bus.cmd_valid, 64'b1000);
    check("pre_rst_cap_toggle", bus.capture_toggle, exp_tog);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_cmd_valid", bus.cmd_valid, 64'd0);
    check("async_rst_busy", bus.busy, 64'd0);
    check("async_rst_cap_toggle", bus.capture_toggle, 64'd0);
    bus.udr_toggle = 1'b0;
    bus.uir_toggle = 1'b0;
    bus.ir_in = '0;
    exp_tog = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("post_rst_err", bus.err_flags, 64'd0);

    // Stalled channel: watchdog abort or indefinite wait.
    set_ir(3'd2);
    fire_udr(1'b1, 32'h01020304);
    check("stall_cmd_valid", bus.cmd_valid, 64'b0100);
`ifdef JTAG_CMD_BRIDGE_TIMEOUT_EN
    repeat (TMO - 1) tick();
    check("tmo_not_yet", bus.busy, 64'd1);
    tick();
    exp_tog = ~exp_tog;
    check("tmo_busy", bus.busy, 64'd0);
    check("tmo_capture", bus.capture_data, 64'hFFFFFFFF);
    check("tmo_cap_toggle", bus.capture_toggle, exp_tog);
    check("tmo_err", bus.err_flags, 64'b100);
    check("tmo_cmd_valid", bus.cmd_valid, 64'd0);
`else
    repeat (3 * TMO) tick();
    check("stall_busy", bus.busy, 64'd1);
    check("stall_cmd_valid_held", bus.cmd_valid, 64'b0100);
    check("stall_err", bus.err_flags, 64'd0);
    sb_q.push_back(32'h77778888);
    finish_cmd(2, 0, 32'h77778888);
`endif
    check("sb_drained", sb_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
